// File: rtl/series_eval_engine.sv
// Sequential power-series evaluator: sum of c[k]*x^k over N_TERMS coefficients read
// one per cycle from an external combinational LUT, unsigned fixed point with saturation.
module series_eval_engine #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int N_TERMS   = 8,
  parameter int FRAC_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] x_in,
  output logic [ADDR_W-1:0] lut_addr,
  input  logic [DATA_W-1:0] lut_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic [DATA_W-1:0] ONE    = DATA_W'(2 ** FRAC_BITS);
  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(N_TERMS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_k;
  logic [DATA_W-1:0] r_x;
  logic [DATA_W-1:0] r_term;
  logic [DATA_W-1:0] r_sum;
  logic [DATA_W-1:0] r_result;

  logic              w_last;
  logic [PROD_W-1:0] w_coef_prod;
  logic [PROD_W-1:0] w_p;
  logic [PROD_W-1:0] w_term_prod;
  logic [DATA_W-1:0] w_sum_next;
  logic [DATA_W-1:0] w_term_next;

  // Clamp any value that does not fit in DATA_W bits to all-ones instead of wrapping.
  function automatic logic [DATA_W-1:0] sat_u(input logic [PROD_W:0] v);
    if (|v[PROD_W:DATA_W]) return '1;
    else                   return v[DATA_W-1:0];
  endfunction

  assign w_last      = (r_k == K_LAST);
  assign w_coef_prod = PROD_W'(lut_data) * PROD_W'(r_term);
  assign w_p         = w_coef_prod >> FRAC_BITS;
  assign w_sum_next  = sat_u({1'b0, w_p} + (PROD_W + 1)'(r_sum));
  assign w_term_prod = PROD_W'(r_term) * PROD_W'(r_x);
  assign w_term_next = sat_u({1'b0, w_term_prod >> FRAC_BITS});

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_next = S_ACC;
      S_ACC: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Result is loaded on the final accumulate edge so it is already valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k      <= '0;
      r_x      <= '0;
      r_term   <= '0;
      r_sum    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x    <= x_in;
            r_term <= ONE;
            r_sum  <= '0;
            r_k    <= '0;
          end
        end
        S_ACC: begin
          r_sum  <= w_sum_next;
          r_term <= w_term_next;
          if (w_last) begin
            r_k      <= '0;
            r_result <= w_sum_next;
          end else begin
            r_k <= r_k + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign lut_addr = r_k;
  assign result   = r_result;

endmodule

// File: tb/tb_series_eval_engine.sv
// Bench for series_eval_engine: directed series cases plus randomized coefficient
// tables and operands checked against a plain-arithmetic reference model.
module tb_series_eval_engine;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 4;
  localparam int N_TERMS   = 8;
  localparam int FRAC_BITS = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [DATA_W-1:0] x_in;
  logic [ADDR_W-1:0] lut_addr;
  logic [DATA_W-1:0] lut_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;

  logic [DATA_W-1:0] coef [16];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign lut_data = coef[lut_addr];

  series_eval_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_TERMS(N_TERMS), .FRAC_BITS(FRAC_BITS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .lut_addr(lut_addr),
    .lut_data(lut_data), .busy(busy), .done(done), .result(result)
  );

  // sum_k c[k]*x^k with each product truncated to FRAC_BITS and clamped at 0xFFFF
  function automatic logic [DATA_W-1:0] model(input logic [DATA_W-1:0] x);
    longint unsigned term, sum, p, c, xv;
    term = 256;
    sum  = 0;
    xv   = x;
    for (int k = 0; k < N_TERMS; k++) begin
      c = coef[k];
      p = (c * term) >> FRAC_BITS;
      sum = sum + p;
      if (sum > 65535) sum = 65535;
      term = (term * xv) >> FRAC_BITS;
      if (term > 65535) term = 65535;
    end
    return sum[DATA_W-1:0];
  endfunction

  task automatic load_std();
    coef = '{16'h0080, 16'h0015, 16'h0008, 16'h0004, 16'h0002, 16'h0001, 16'h0001, 16'h0001,
             16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
  endtask

  // Starts a run, checks every ACC cycle and the done cycle; returns while in the done cycle.
  task automatic run_eval(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] exp,
                          input int repulse, input string name);
    @(posedge clk); #1;
    start = 1'b1;
    x_in  = x;
    @(posedge clk); #1;
    start = 1'b0;
    x_in  = DATA_W'($urandom);
    for (int c = 1; c <= N_TERMS; c++) begin
      n_tests++;
      if (busy !== 1'b1 || done !== 1'b0 || lut_addr !== ADDR_W'(c - 1)) begin
        n_fail++;
        $display("FAIL %s acc cycle %0d: busy=%b done=%b lut_addr=%0d, required busy=1 done=0 lut_addr=%0d",
                 name, c, busy, done, lut_addr, c - 1);
      end
      if (c == repulse) begin
        start = 1'b1;
        x_in  = '0;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== exp || lut_addr !== '0) begin
      n_fail++;
      $display("FAIL %s done cycle: done=%b busy=%b result=%h lut_addr=%0d, required done=1 busy=0 result=%h lut_addr=0",
               name, done, busy, result, lut_addr, exp);
    end
  endtask

  task automatic test_idle_hold(input logic [DATA_W-1:0] exp, input string name);
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== exp || lut_addr !== '0) begin
      n_fail++;
      $display("FAIL %s idle hold: done=%b busy=%b result=%h lut_addr=%0d, required 0 0 %h 0",
               name, done, busy, result, lut_addr, exp);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    x_in  = '0;
    load_std();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || lut_addr !== '0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b result=%h lut_addr=%0d, required all zero",
               busy, done, result, lut_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_x_zero();
    load_std();
    run_eval(16'h0000, 16'h0080, 0, "x_zero");
    test_idle_hold(16'h0080, "x_zero");
  endtask

  task automatic test_x_one();
    run_eval(16'h0100, 16'h00A6, 0, "x_one");
    test_idle_hold(16'h00A6, "x_one");
  endtask

  task automatic test_x_half();
    run_eval(16'h0080, model(16'h0080), 0, "x_half");
    test_idle_hold(model(16'h0080), "x_half");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 16; i++) coef[i] = 16'hFFFF;
    run_eval(16'hFFFF, 16'hFFFF, 0, "saturation");
    test_idle_hold(16'hFFFF, "saturation");
    load_std();
  endtask

  task automatic test_back_to_back();
    run_eval(16'h0100, 16'h00A6, 3, "ignore_start");
    run_eval(16'h0080, model(16'h0080), 0, "back_to_back");
    test_idle_hold(model(16'h0080), "back_to_back");
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    @(posedge clk); #1;
    start = 1'b1;
    x_in  = 16'h0100;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || lut_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h lut_addr=%0d, required all zero",
               busy, done, result, lut_addr);
    end
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_tests++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: done pulse seen=1, required 0");
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] x;
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 16; i++)
        coef[i] = (it % 3 == 0) ? DATA_W'($urandom) : DATA_W'($urandom_range(0, 16'h0200));
      x = (it % 2 == 0) ? DATA_W'($urandom_range(0, 16'h0200)) : DATA_W'($urandom);
      run_eval(x, model(x), 0, $sformatf("random_%0d", it));
    end
    test_idle_hold(model(x), "random_last");
  endtask

  initial begin
    test_reset();
    test_x_zero();
    test_x_one();
    test_x_half();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
